cdb_arbiter: RTL

//  Common-data-bus source for the Tomasulo core. Collects completed results from the ALU and the LSB.

---
 rtl/cdb_arbiter_if.sv | 30 +++
 rtl/cdb_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// Result bus between the two producers (ALU, LSB) and the CDB arbiter.
// The producer side pushes results and watches its full flag; the arbiter
// side drives the registered tag/data broadcast seen by rs, LSB and ROB.
interface cdb_arbiter_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_data;
    logic              alu_full;
    logic              lsb_valid;
    logic [TAG_W-1:0]  lsb_tag;
    logic [DATA_W-1:0] lsb_data;
    logic              lsb_full;
    logic [TAG_W-1:0]  tag_renew;
    logic [DATA_W-1:0] data_renew;

    modport master (
        output alu_valid, alu_tag, alu_data,
        output lsb_valid, lsb_tag, lsb_data,
        input  alu_full, lsb_full, tag_renew, data_renew
    );

    modport slave (
        input  alu_valid, alu_tag, alu_data,
        input  lsb_valid, lsb_tag, lsb_data,
        output alu_full, lsb_full, tag_renew, data_renew
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus source for the Tomasulo core. Each result source (ALU,
// LSB) owns a small FIFO; a round-robin arbiter pops one entry per ready
// cycle into the registered tag_renew/data_renew broadcast (tag 0 = idle).
// Optional feature macro: CDB_BYPASS_EN -- a result arriving at an empty
// FIFO whose source wins arbitration goes straight to the broadcast register.
// Source index 0 is the ALU, index 1 is the LSB.
module cdb_arbiter #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         clear,
    cdb_arbiter_if.slave bus
);
    localparam int   PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int   CNT_W   = $clog2(DEPTH + 1);
    localparam logic SRC_LSB = 1'b1;

    // FIFO storage: data only, never reset
    logic [TAG_W-1:0]  tag_mem_q  [2][DEPTH];
    logic [DATA_W-1:0] data_mem_q [2][DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  cnt_q    [2];
    logic [CNT_W-1:0]  cnt_d    [2];
    logic              last_grant_q, last_grant_d;
    logic [TAG_W-1:0]  tag_renew_q, tag_renew_d;
    logic [DATA_W-1:0] data_renew_q, data_renew_d;

    logic [TAG_W-1:0]  src_tag  [2];
    logic [DATA_W-1:0] src_data [2];
    logic [1:0]        src_valid;
    logic [1:0]        full;
    logic [1:0]        nonempty;
    logic [1:0]        push_ok;
    logic [1:0]        cand;
    logic [1:0]        pop;
    logic [1:0]        wr;
    logic              any_cand;
    logic              grant;
    logic              bypass_hit;

    assign src_valid   = {bus.lsb_valid, bus.alu_valid};
    assign src_tag[0]  = bus.alu_tag;
    assign src_tag[1]  = bus.lsb_tag;
    assign src_data[0] = bus.alu_data;
    assign src_data[1] = bus.lsb_data;

    // Full is a pure function of the count; a same-cycle pop does not free a slot
    assign full     = {(cnt_q[1] == CNT_W'(DEPTH)), (cnt_q[0] == CNT_W'(DEPTH))};
    assign nonempty = {(cnt_q[1] != '0), (cnt_q[0] != '0)};
    assign push_ok  = src_valid & {(src_tag[1] != '0), (src_tag[0] != '0)} & ~full;

`ifdef CDB_BYPASS_EN
    // An empty FIFO with an incoming result competes as if it already held it
    assign cand = nonempty | push_ok;
`else
    assign cand = nonempty;
`endif

    assign bus.alu_full   = full[0];
    assign bus.lsb_full   = full[1];
    assign bus.tag_renew  = tag_renew_q;
    assign bus.data_renew = data_renew_q;

    // Round-robin grant: on a tie the source that did not win last time goes
    always_comb begin
        any_cand   = |cand;
        grant      = 1'b0;
        bypass_hit = 1'b0;
        pop        = 2'b00;
        wr         = push_ok;
        if (&cand) begin
            grant = ~last_grant_q;
        end else begin
            grant = cand[1];
        end
        if (any_cand) begin
            if (nonempty[grant]) begin
                pop[grant] = 1'b1;
            end else begin
                // Winner's FIFO is empty, so its input skips the FIFO entirely
                bypass_hit = 1'b1;
                wr[grant]  = 1'b0;
            end
        end
    end

    // Next-state for pointers, counts, grant history and the broadcast register
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            wr_ptr_d[s] = wr_ptr_q[s];
            rd_ptr_d[s] = rd_ptr_q[s];
            cnt_d[s]    = cnt_q[s];
        end
        last_grant_d = last_grant_q;
        tag_renew_d  = tag_renew_q;
        data_renew_d = data_renew_q;
        if (rdy) begin
            if (clear) begin
                for (int s = 0; s < 2; s++) begin
                    wr_ptr_d[s] = '0;
                    rd_ptr_d[s] = '0;
                    cnt_d[s]    = '0;
                end
                last_grant_d = SRC_LSB;
                tag_renew_d  = '0;
                data_renew_d = '0;
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (wr[s]) begin
                        wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
                    end
                    if (pop[s]) begin
                        rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
                    end
                    cnt_d[s] = cnt_q[s] + CNT_W'(wr[s]) - CNT_W'(pop[s]);
                end
                if (any_cand) begin
                    last_grant_d = grant;
                    if (bypass_hit) begin
                        tag_renew_d  = src_tag[grant];
                        data_renew_d = src_data[grant];
                    end else begin
                        tag_renew_d  = tag_mem_q[grant][rd_ptr_q[grant]];
                        data_renew_d = data_mem_q[grant][rd_ptr_q[grant]];
                    end
                end else begin
                    tag_renew_d  = '0;
                    data_renew_d = '0;
                end
            end
        end
    end

    // Control and broadcast registers; asynchronous reset returns to idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
            last_grant_q <= SRC_LSB;
            tag_renew_q  <= '0;
            data_renew_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                cnt_q[s]    <= cnt_d[s];
            end
            last_grant_q <= last_grant_d;
            tag_renew_q  <= tag_renew_d;
            data_renew_q <= data_renew_d;
        end
    end

    // FIFO writes; dropped while frozen or flushing
    always_ff @(posedge clk) begin
        if (rdy && !clear) begin
            for (int s = 0; s < 2; s++) begin
                if (wr[s]) begin
                    tag_mem_q[s][wr_ptr_q[s]]  <= src_tag[s];
                    data_mem_q[s][wr_ptr_q[s]] <= src_data[s];
                end
            end
        end
    end
endmodule
